frame_writer_sdram: RTL and testbench
=====================================

// Module: frame_writer_sdram
// PURPOSE
//  Write-side counterpart of the VGA row reader. Packs 16-bit camera pixels into 128-bit words
//  and issues single-beat write requests to the SDRAM controller. Frames go into a ring of frame
//  slots. After a frame is fully written, the block publishes last_frame, which the display side
//  uses to choose its read base. Sits between camera capture (pixels already in 133 MHz domain) and SDRAM ctrl.
// PARAMETERS
//  FIFO_DEPTH   8          128-bit words buffered between packer and SDRAM (power of 2)
//  NUM_SLOTS    6          frame slots in SDRAM ring
//  SLOT_STRIDE  25'h25800  address distance between slot bases (slot k base = k*SLOT_STRIDE)
//  FRAME_WORDS  38400      128-bit words per frame (640x480 px / 8)
//  ADDR_STEP    4          address increment per 128-bit word
// PORTS
//  clk_133M     in   1    sole clock
//  rst_n_133M   in   1    asynchronous, active-low reset
//  start_frame  in   1    level from capture; rising edge (registered) = new frame begins
//  pixel_valid  in   1    pixel_data valid this cycle
//  pixel_data   in   16   RGB565 pixel
//  ram_busy     in   1    SDRAM ctrl cannot accept a request
//  wr_req       out  1    one-cycle write request
//  wr_address   out  25   write address; valid with wr_req
//  wr_data      out  128  write data; valid with wr_req
//  last_frame   out  3    slot index of most recently completed frame
//  frame_done   out  1    one-cycle pulse when last_frame updates
//  overflow     out  1    sticky: a word was dropped, or a frame was aborted
// BEHAVIOUR
//  Reset values: wr_req=0, wr_address=0, wr_data=0, last_frame=0, frame_done=0, overflow=0.
//  Internal reset values: FSM=IDLE, FIFO empty, pack count=0, word count=0.
//  FSM IDLE->ACTIVE on start_frame edge; sets slot=(last_frame+1)%NUM_SLOTS, base=slot*SLOT_STRIDE.
//  Slot arithmetic wraps: last_frame=5 -> slot 0.
//  Packing: the k-th valid pixel (k=0..7) goes to bits [16k+15:16k]; pixel 0 lands in the LSBs,
//   matching the reader's 16-bit readout order.
//  On the 8th pixel, the completed word is pushed into the FIFO in the same cycle. Word count increments.
//  pixel_valid in IDLE or DRAIN is ignored.
//  ACTIVE->DRAIN when word count reaches FRAME_WORDS.
//  DRAIN->IDLE when the FIFO is empty and no request is pending. In that cycle:
//   last_frame<=slot; frame_done=1 for one cycle.
//  Request issue: wr_req is registered. It is asserted at edge N+1 when all hold at edge N:
//   FIFO non-empty, ram_busy==0, wr_req==0. No back-to-back requests (ctrl raises busy one cycle late).
//   Issue pops the FIFO head into wr_data. wr_address = base + ADDR_STEP*words_issued.
//  A request is considered accepted when it is issued. No retry path.
//  FIFO full when a word completes: the word is dropped; overflow<=1; word count still increments,
//   so frame length is preserved.
//  start_frame edge in ACTIVE/DRAIN: abort. Partial pack and FIFO are discarded; overflow<=1.
//   last_frame is unchanged. Restart in ACTIVE with the same slot and base.
//  A pixel arriving in the same cycle as a start_frame edge is the first pixel of the new frame.
//  Simultaneous FIFO push and pop are allowed; count unchanged.
//  Reset mid-frame returns all state to reset values immediately (async). No partial frame is published.
// STRUCTURE
//  Shared package: NUM_SLOTS, SLOT_STRIDE, FRAME_WORDS, ADDR_STEP, frame-geometry constants
//   (shared with the VGA row reader), FSM state enum {IDLE, ACTIVE, DRAIN}.
//  Sub-module: sync_fifo_128 (single-clock FIFO, FIFO_DEPTH x 128, full/empty flags, sync flush).
//  Top level holds the packer, counters, FSM and request issue.
// TESTING
//  1. Reset; start_frame edge; pixels 16'h0001..16'h0008 with ram_busy=0
//     -> one wr_req, wr_address=25'h25800, wr_data=128'h0008_0007_..._0001.
//  2. Full frame (307200 px, ram_busy=0) from last_frame=0
//     -> 38400 wr_req; final address 25'h25800+4*38399; frame_done pulse; last_frame=1.
//  3. Six back-to-back frames -> last_frame sequence 1,2,3,4,5,0; frame 6 base = 25'h0.
//  4. Hold ram_busy=1 while streaming 72 px -> 8 words fill FIFO; 9th dropped; overflow=1;
//     after release, exactly 8 wr_req at consecutive +4 addresses.
//  5. Toggle ram_busy (1 low cycle in 3) -> no wr_req while ram_busy=1; never two consecutive wr_req cycles.
//  6. start_frame edge after 1000 px -> overflow=1; no frame_done; new frame restarts at same base
//     25'h25800; assert rst_n_133M mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/frame_writer_sdram_pkg.sv
`default_nettype none
//==============================================================================
// frame_writer_sdram_pkg : constants and types shared by the SDRAM frame writer
// Rev 1.0
//==============================================================================
package frame_writer_sdram_pkg;

   localparam int ADDR_W       = 25;
   localparam int DATA_W       = 128;
   localparam int PIX_W        = 16;
   localparam int SLOT_W       = 3;
   localparam int PIX_PER_WORD = DATA_W / PIX_W;

   // Frame geometry, identical to what the VGA row reader assumes
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   localparam int                DEF_FIFO_DEPTH  = 8;
   localparam int                DEF_NUM_SLOTS   = 6;
   localparam logic [ADDR_W-1:0] DEF_SLOT_STRIDE = 25'h25800;
   localparam int                DEF_FRAME_WORDS = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
   localparam int                DEF_ADDR_STEP   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } fw_state_t;

   function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_W-1:0] slot,
                                                   input logic [ADDR_W-1:0] stride);
      return ADDR_W'(slot) * stride;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_128.sv
`default_nettype none
//==============================================================================
// sync_fifo_128 : single-clock FIFO with full/empty flags and synchronous flush
// Rev 1.0
//==============================================================================
module sync_fifo_128 #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop & ~o_empty;
   // A push into a full FIFO still lands when the head leaves in the same cycle
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/frame_writer_sdram.sv
`default_nettype none
//==============================================================================
// frame_writer_sdram : packs camera pixels into 128-bit words, writes them to a
//                      ring of SDRAM frame slots and publishes the last full slot
// Rev 1.0
//==============================================================================
module frame_writer_sdram
   import frame_writer_sdram_pkg::*;
#(
   parameter int                FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int                NUM_SLOTS   = DEF_NUM_SLOTS,
   parameter logic [ADDR_W-1:0] SLOT_STRIDE = DEF_SLOT_STRIDE,
   parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
   parameter int                ADDR_STEP   = DEF_ADDR_STEP
) (
   input  logic              clk_133M,
   input  logic              rst_n_133M,
   input  logic              start_frame,
   input  logic              pixel_valid,
   input  logic [PIX_W-1:0]  pixel_data,
   input  logic              ram_busy,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_address,
   output logic [DATA_W-1:0] wr_data,
   output logic [SLOT_W-1:0] last_frame,
   output logic              frame_done,
   output logic              overflow
);

   localparam int WCNT_W = $clog2(FRAME_WORDS + 1);
   localparam int PCNT_W = $clog2(PIX_PER_WORD);

   fw_state_t                r_state;
   fw_state_t                w_state_nxt;
   logic                     r_start_d;
   logic [PCNT_W-1:0]        r_pack_cnt;
   logic [DATA_W-PIX_W-1:0]  r_pack;
   logic [WCNT_W-1:0]        r_word_cnt;
   logic [WCNT_W-1:0]        r_issue_cnt;
   logic [SLOT_W-1:0]        r_slot;
   logic [ADDR_W-1:0]        r_base;
   logic                     r_wr_req;
   logic [ADDR_W-1:0]        r_wr_address;
   logic [DATA_W-1:0]        r_wr_data;
   logic [SLOT_W-1:0]        r_last_frame;
   logic                     r_frame_done;
   logic                     r_overflow;

   logic                     w_start_edge;
   logic                     w_abort;
   logic                     w_pix_take;
   logic [PCNT_W-1:0]        w_pack_idx;
   logic                     w_word_done;
   logic [DATA_W-1:0]        w_word;
   logic                     w_issue;
   logic                     w_drop;
   logic                     w_publish;
   logic [SLOT_W-1:0]        w_next_slot;
   logic [DATA_W-1:0]        w_fifo_head;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;

   assign w_start_edge = start_frame & ~r_start_d;
   assign w_abort      = w_start_edge & (r_state != ST_IDLE);
   // The pixel coinciding with a start edge is pixel 0 of the new frame
   assign w_pix_take   = pixel_valid & (w_start_edge | (r_state == ST_ACTIVE));
   assign w_pack_idx   = w_start_edge ? '0 : r_pack_cnt;
   assign w_word_done  = w_pix_take & (w_pack_idx == PCNT_W'(PIX_PER_WORD - 1));
   assign w_word       = {pixel_data, r_pack};
   assign w_issue      = ~w_fifo_empty & ~ram_busy & ~r_wr_req & ~w_abort;
   assign w_drop       = w_word_done & w_fifo_full & ~w_issue;
   assign w_next_slot  = (r_last_frame == SLOT_W'(NUM_SLOTS - 1)) ? '0
                                                                   : r_last_frame + SLOT_W'(1);

   sync_fifo_128 #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk_133M),
      .rst_n   (rst_n_133M),
      .i_flush (w_abort),
      .i_push  (w_word_done),
      .i_pop   (w_issue),
      .i_data  (w_word),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_publish   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_edge) w_state_nxt = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (w_abort)
               w_state_nxt = ST_ACTIVE;
            else if (w_word_done && (r_word_cnt == WCNT_W'(FRAME_WORDS - 1)))
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_abort) begin
               w_state_nxt = ST_ACTIVE;
            end else if (w_fifo_empty && !r_wr_req) begin
               w_state_nxt = ST_IDLE;
               w_publish   = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_133M or negedge rst_n_133M) begin
      if (!rst_n_133M) begin
         r_state      <= ST_IDLE;
         r_start_d    <= 1'b0;
         r_pack_cnt   <= '0;
         r_pack       <= '0;
         r_word_cnt   <= '0;
         r_issue_cnt  <= '0;
         r_slot       <= '0;
         r_base       <= '0;
         r_wr_req     <= 1'b0;
         r_wr_address <= '0;
         r_wr_data    <= '0;
         r_last_frame <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_start_d    <= start_frame;
         r_frame_done <= w_publish;
         if (w_publish) r_last_frame <= r_slot;

         // An abort keeps the slot chosen when the frame first started
         if (w_start_edge && (r_state == ST_IDLE)) begin
            r_slot <= w_next_slot;
            r_base <= slot_base(w_next_slot, SLOT_STRIDE);
         end

         if (w_abort || w_drop) r_overflow <= 1'b1;

         if (w_pix_take) begin
            r_pack_cnt <= w_word_done ? '0 : w_pack_idx + PCNT_W'(1);
            for (int k = 0; k < PIX_PER_WORD - 1; k++) begin
               if (w_pack_idx == PCNT_W'(k)) r_pack[k*PIX_W +: PIX_W] <= pixel_data;
            end
         end else if (w_start_edge) begin
            r_pack_cnt <= '0;
         end

         if (w_start_edge)     r_word_cnt <= '0;
         else if (w_word_done) r_word_cnt <= r_word_cnt + WCNT_W'(1);

         if (w_start_edge) r_issue_cnt <= '0;
         else if (w_issue) r_issue_cnt <= r_issue_cnt + WCNT_W'(1);

         r_wr_req <= w_issue;
         if (w_issue) begin
            r_wr_address <= r_base + ADDR_W'(r_issue_cnt) * ADDR_W'(ADDR_STEP);
            r_wr_data    <= w_fifo_head;
         end
      end
   end

   assign wr_req     = r_wr_req;
   assign wr_address = r_wr_address;
   assign wr_data    = r_wr_data;
   assign last_frame = r_last_frame;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_frame_writer_sdram.sv
`default_nettype none
//==============================================================================
// tb_frame_writer_sdram : directed self-checking bench for frame_writer_sdram
// Rev 1.0
//==============================================================================
module tb_frame_writer_sdram;

   localparam int FW = 200;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_frame;
   logic          pixel_valid;
   logic [15:0]   pixel_data;
   logic          ram_busy;
   logic          wr_req;
   logic [24:0]   wr_address;
   logic [127:0]  wr_data;
   logic [2:0]    last_frame;
   logic          frame_done;
   logic          overflow;

   int            n_checks = 0;
   int            n_err = 0;
   int            busy_mode = 0;
   int            cyc_n = 0;
   int            fd_cnt = 0;
   int            n_busy_viol = 0;
   int            n_b2b = 0;
   logic          prev_req = 1'b0;
   logic          prev_busy = 1'b0;
   logic [24:0]   q_addr[$];
   logic [127:0]  q_data[$];

   typedef struct {
      logic         sf;
      logic         pv;
      logic [15:0]  pd;
      logic         exp_req;
      logic [24:0]  exp_addr;
      logic [127:0] exp_data;
   } vec_t;

   vec_t vecs[10];

   frame_writer_sdram #(.FRAME_WORDS(FW)) dut (
      .clk_133M    (clk),
      .rst_n_133M  (rst_n),
      .start_frame (start_frame),
      .pixel_valid (pixel_valid),
      .pixel_data  (pixel_data),
      .ram_busy    (ram_busy),
      .wr_req      (wr_req),
      .wr_address  (wr_address),
      .wr_data     (wr_data),
      .last_frame  (last_frame),
      .frame_done  (frame_done),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Request log; a request seen here depends on ram_busy seen one negedge earlier
   always @(negedge clk) begin
      if (wr_req) begin
         q_addr.push_back(wr_address);
         q_data.push_back(wr_data);
         if (prev_busy) n_busy_viol++;
         if (prev_req)  n_b2b++;
      end
      if (frame_done) fd_cnt++;
      prev_req  = wr_req;
      prev_busy = ram_busy;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic pv, input logic [15:0] pd);
      pixel_valid = pv;
      pixel_data  = pd;
      case (busy_mode)
         0:       ram_busy = 1'b0;
         1:       ram_busy = 1'b1;
         default: ram_busy = ((cyc_n % 3) != 0);
      endcase
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] exp_word(input int w);
      logic [127:0] r;
      for (int j = 0; j < 8; j++) r[16*j +: 16] = 16'(8*w + j + 1);
      return r;
   endfunction

   function automatic logic [24:0] base_of(input int slot);
      return 25'(slot) * 25'h25800;
   endfunction

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      fd_cnt = 0;
   endtask

   task automatic check_q(input logic [24:0] base, input int n);
      int ae = 0;
      int de = 0;
      chk("req_count", 128'(q_addr.size()), 128'(n));
      chk("first_addr", (q_addr.size() > 0) ? {103'd0, q_addr[0]} : '1, {103'd0, base});
      for (int i = 0; i < n && i < q_addr.size(); i++) begin
         if (q_addr[i] !== base + 25'(4*i)) ae++;
         if (q_data[i] !== exp_word(i))     de++;
      end
      chk("addr_seq_errs", 128'(ae), 128'(0));
      chk("data_seq_errs", 128'(de), 128'(0));
   endtask

   task automatic start_and_stream(input int n);
      start_frame = 1'b0;
      cyc(1'b0, 16'h0);
      clear_log();
      start_frame = 1'b1;
      for (int i = 0; i < n; i++) cyc(1'b1, 16'(i + 1));
   endtask

   task automatic finish_frame(input int slot);
      for (int t = 0; t < 500 && fd_cnt == 0; t++) cyc(1'b0, 16'h0);
      cyc(1'b0, 16'h0);
      cyc(1'b0, 16'h0);
      chk("frame_done_pulses", 128'(fd_cnt), 128'(1));
      chk("last_frame", {125'd0, last_frame}, 128'(slot));
      check_q(base_of(slot), FW);
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      start_frame = 1'b0;
      cyc(1'b0, 16'h0);
      cyc(1'b0, 16'h0);
      rst_n = 1'b1;
      cyc(1'b0, 16'h0);
   endtask

   initial begin
      rst_n       = 1'b0;
      start_frame = 1'b0;
      pixel_valid = 1'b0;
      pixel_data  = 16'h0;
      ram_busy    = 1'b0;

      for (int i = 0; i < 10; i++) begin
         vecs[i].sf       = 1'b1;
         vecs[i].pv       = (i < 8);
         vecs[i].pd       = (i < 8) ? 16'(i + 1) : 16'h0;
         vecs[i].exp_req  = (i == 8);
         vecs[i].exp_addr = 25'h25800;
         vecs[i].exp_data = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
      end

      cyc(1'b0, 16'h0);
      cyc(1'b0, 16'h0);
      chk("rst_wr_req", 128'(wr_req), 128'(0));
      chk("rst_wr_address", 128'(wr_address), 128'(0));
      chk("rst_wr_data", wr_data, 128'(0));
      chk("rst_last_frame", 128'(last_frame), 128'(0));
      chk("rst_frame_done", 128'(frame_done), 128'(0));
      chk("rst_overflow", 128'(overflow), 128'(0));
      rst_n = 1'b1;
      cyc(1'b0, 16'h0);
      clear_log();

      // First word of a frame from last_frame=0, then the rest of that frame
      for (int i = 0; i < 10; i++) begin
         start_frame = vecs[i].sf;
         cyc(vecs[i].pv, vecs[i].pd);
         chk("vec_wr_req", 128'(wr_req), 128'(vecs[i].exp_req));
         if (vecs[i].exp_req) begin
            chk("vec_wr_address", 128'(wr_address), 128'(vecs[i].exp_addr));
            chk("vec_wr_data", wr_data, vecs[i].exp_data);
         end
      end
      chk("vec_overflow", 128'(overflow), 128'(0));
      for (int i = 8; i < FW*8; i++) cyc(1'b1, 16'(i + 1));
      finish_frame(1);

      // Ring wrap: slots 2,3,4,5,0
      for (int f = 2; f <= 6; f++) begin
         start_and_stream(FW*8);
         finish_frame(f % 6);
      end
      chk("no_overflow_ring", 128'(overflow), 128'(0));

      // FIFO fill under permanent busy: 9th word dropped
      busy_mode = 1;
      start_and_stream(72);
      chk("busy_overflow", 128'(overflow), 128'(1));
      chk("busy_no_req", 128'(q_addr.size()), 128'(0));
      busy_mode = 0;
      repeat (30) cyc(1'b0, 16'h0);
      check_q(25'h25800, 8);

      // Toggling busy
      do_reset();
      busy_mode   = 2;
      n_busy_viol = 0;
      n_b2b       = 0;
      start_and_stream(FW*8);
      finish_frame(1);
      busy_mode = 0;
      chk("req_while_busy", 128'(n_busy_viol), 128'(0));
      chk("back_to_back_req", 128'(n_b2b), 128'(0));
      chk("toggle_overflow", 128'(overflow), 128'(0));

      // Abort after 1000 pixels, restart in the same slot
      do_reset();
      start_and_stream(1000);
      start_frame = 1'b0;
      cyc(1'b0, 16'h0);
      start_frame = 1'b1;
      cyc(1'b1, 16'h1);
      chk("abort_overflow", 128'(overflow), 128'(1));
      chk("abort_last_frame", 128'(last_frame), 128'(0));
      chk("abort_no_frame_done", 128'(fd_cnt), 128'(0));
      clear_log();
      for (int i = 1; i < FW*8; i++) cyc(1'b1, 16'(i + 1));
      finish_frame(1);

      // Asynchronous reset mid-frame
      start_and_stream(100);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_req", 128'(wr_req), 128'(0));
      chk("midrst_wr_address", 128'(wr_address), 128'(0));
      chk("midrst_wr_data", wr_data, 128'(0));
      chk("midrst_last_frame", 128'(last_frame), 128'(0));
      chk("midrst_frame_done", 128'(frame_done), 128'(0));
      chk("midrst_overflow", 128'(overflow), 128'(0));
      start_frame = 1'b0;
      cyc(1'b0, 16'h0);
      rst_n = 1'b1;
      cyc(1'b0, 16'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
